// File: rtl/axis_gpio_multi.sv
// AXI-Stream to multi-channel GPIO: captures fixed-offset big-endian fields into per-channel
// shadows and publishes them to gpio_out. Define AXIS_GPIO_MULTI_ATOMIC_EN for all-at-once update.
module axis_gpio_multi #(
  parameter int AXI_WIDTH  = 8,
  parameter int GPIO_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int BYTE_START = 31,
  parameter int CH_STRIDE  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXI_WIDTH-1:0]         s_axis_data,
  input  logic                         s_axis_valid,
  input  logic                         s_axis_last,
  output logic                         s_axis_ready,
  output logic [NUM_CH*GPIO_WIDTH-1:0] gpio_out,
  output logic                         gpio_update,
  output logic                         short_pkt
);

  localparam int W       = GPIO_WIDTH / AXI_WIDTH;
  localparam int END_IDX = BYTE_START + (NUM_CH - 1) * CH_STRIDE + W - 1;
  localparam int CNT_W   = $clog2(END_IDX + 2);

  typedef enum logic [1:0] {StSeek, StCapture, StDone} state_e;

  // With BYTE_START=0 the very first beat of a packet is already inside channel 0's field.
  localparam state_e START_ST = (BYTE_START == 0) ? StCapture : StSeek;

  state_e                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [GPIO_WIDTH-1:0]         r_shadow [NUM_CH];
  logic [NUM_CH*GPIO_WIDTH-1:0]  r_gpio;
  logic                          r_update;
  logic                          r_short;

  logic                          w_beat;
  logic                          w_last_beat;
  logic                          w_short;
  logic [NUM_CH-1:0]             w_win;
  logic [NUM_CH-1:0]             w_fin;
  logic [GPIO_WIDTH-1:0]         w_shadow_nxt [NUM_CH];

  assign s_axis_ready = ~rst;
  assign w_beat       = s_axis_valid & s_axis_ready;
  assign w_last_beat  = w_beat & s_axis_last;
  assign w_short      = w_last_beat & (r_cnt < CNT_W'(END_IDX));

  assign gpio_out    = r_gpio;
  assign gpio_update = r_update;
  assign short_pkt   = r_short;

  always_comb begin
    w_win = '0;
    w_fin = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // Shift left so the first beat of the field ends up in the MSBs.
      w_shadow_nxt[c] = (r_shadow[c] << AXI_WIDTH) | GPIO_WIDTH'(s_axis_data);
      w_win[c] = (r_state == StCapture) &&
                 (r_cnt >= CNT_W'(BYTE_START + c * CH_STRIDE)) &&
                 (r_cnt <= CNT_W'(BYTE_START + c * CH_STRIDE + W - 1));
      w_fin[c] = (r_cnt == CNT_W'(BYTE_START + c * CH_STRIDE + W - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= START_ST;
      r_cnt    <= '0;
      r_gpio   <= '0;
      r_update <= 1'b0;
      r_short  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) r_shadow[c] <= '0;
    end else begin
      r_update <= 1'b0;
      r_short  <= 1'b0;
      if (w_beat) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_win[c]) r_shadow[c] <= w_shadow_nxt[c];
        end
`ifndef AXIS_GPIO_MULTI_ATOMIC_EN
        // A short packet ending on a field's final word wins, so the two pulses never coincide.
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_win[c] && w_fin[c] && !w_short) begin
            r_gpio[c*GPIO_WIDTH +: GPIO_WIDTH] <= w_shadow_nxt[c];
            r_update <= 1'b1;
          end
        end
`endif
        if (s_axis_last) begin
          r_cnt   <= '0;
          r_state <= START_ST;
          for (int c = 0; c < NUM_CH; c++) r_shadow[c] <= '0;
          if (w_short) begin
            r_short <= 1'b1;
          end
`ifdef AXIS_GPIO_MULTI_ATOMIC_EN
          else begin
            for (int c = 0; c < NUM_CH; c++) begin
              r_gpio[c*GPIO_WIDTH +: GPIO_WIDTH] <= w_win[c] ? w_shadow_nxt[c] : r_shadow[c];
            end
            r_update <= 1'b1;
          end
`endif
        end else begin
          if (r_cnt != CNT_W'(END_IDX + 1)) r_cnt <= r_cnt + 1'b1;
          case (r_state)
            StSeek:    if (r_cnt == CNT_W'(BYTE_START - 1)) r_state <= StCapture;
            StCapture: if (r_cnt == CNT_W'(END_IDX)) r_state <= StDone;
            default:   r_state <= r_state;
          endcase
        end
      end
    end
  end

endmodule
